// File: rtl/rr_req_arbiter.sv
// Purpose:      round-robin arbiter funnelling NUM_REQ requesters onto one datapath, routing in-order responses back by tag.
// Latency:      grant and capture in cycle 0, dut_req_valid_o from cycle 1; response routed combinationally in its arrival cycle.
// Backpressure: dut_req_ready_i low holds the captured request; no captures while MAX_OUTST requests are in flight.
//
// Ports:
//   clk_i, rstn_i                       clock, asynchronous active-low reset
//   req_valid_i / req_data_i / req_ready_o   per-requester request side (ready is one-hot or zero)
//   dut_req_valid_o / dut_req_data_o / dut_req_ready_i   request toward the shared datapath
//   dut_resp_valid_i / dut_resp_data_i   in-order datapath response, never stalled
//   resp_valid_o / resp_data_o           routed response (valid one-hot or zero, data shared)
//   err_o                                sticky: response arrived with nothing in flight

// Tag FIFO: in-order store of grant ids.
// Latency:      head valid the cycle after push; pop takes effect at the clock edge.
// Backpressure: push ignored when full, pop ignored when empty.
module rr_tag_fifo #(
    parameter  int WIDTH = 2,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push_vld && (count != CNT_W'(DEPTH));
    assign do_pop   = pop_vld && (count != '0);
    assign head_dat = mem[rd_ptr];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

module rr_req_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic                           dut_req_valid_o,
    output logic [DATA_SIZE-1:0]           dut_req_data_o,
    input  logic                           dut_req_ready_i,
    input  logic                           dut_resp_valid_i,
    input  logic [DATA_SIZE-1:0]           dut_resp_data_i,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic [DATA_SIZE-1:0]           resp_data_o,
    output logic                           err_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      last_grant;
    logic [ID_W-1:0]      grant_id;
    logic [ID_W-1:0]      winner;
    logic                 found;
    logic [DATA_SIZE-1:0] hold_data;
    logic [CNT_W-1:0]     outst;
    logic [ID_W-1:0]      tag_head;
    logic                 credit_ok;
    logic                 capture;
    logic                 handshake;
    logic                 resp_fire;
    logic                 resp_orphan;

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        logic [ID_W-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req_valid_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign credit_ok = (outst != CNT_W'(MAX_OUTST));
    // rstn_i gating keeps every output at zero while reset is held.
    assign capture     = rstn_i && (state == IDLE) && found && credit_ok;
    assign handshake   = (state == HOLD) && dut_req_ready_i;
    assign resp_fire   = rstn_i && dut_resp_valid_i && (outst != '0);
    assign resp_orphan = dut_resp_valid_i && (outst == '0);

    // FSM: state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture)   state_nxt = HOLD;
            HOLD:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready_o     = '0;
        dut_req_valid_o = 1'b0;
        if (capture) begin
            req_ready_o = NUM_REQ'(1) << winner;
        end
        if (state == HOLD) begin
            dut_req_valid_o = 1'b1;
        end
    end

    assign dut_req_data_o = hold_data;

    // Datapath: captured request, grant bookkeeping, sticky error.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hold_data  <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            err_o      <= 1'b0;
        end else begin
            if (capture) begin
                hold_data <= req_data_i[winner*DATA_SIZE +: DATA_SIZE];
                grant_id  <= winner;
            end
            // Pointer moves only once the datapath has taken the request.
            if (handshake) begin
                last_grant <= grant_id;
            end
            if (resp_orphan) begin
                err_o <= 1'b1;
            end
        end
    end

    // The FIFO occupancy is the in-flight count; push and pop in one cycle cancel.
    rr_tag_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push_vld (capture),
        .push_dat (winner),
        .pop_vld  (resp_fire),
        .head_dat (tag_head),
        .count    (outst)
    );

    assign resp_valid_o = resp_fire ? (NUM_REQ'(1) << tag_head) : '0;
    assign resp_data_o  = resp_fire ? dut_resp_data_i : '0;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Purpose:      self-checking bench for rr_req_arbiter (NUM_REQ=4, DATA_SIZE=16, MAX_OUTST=4).
// Latency:      inputs applied 1 ns after each rising edge, outputs sampled 2 ns later.
// Backpressure: expected response owners queue up as grants are stimulated and are popped per response.
module tb_rr_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int MO = 4;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic [NR-1:0]    req_valid_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    req_ready_o;
    logic             dut_req_valid_o;
    logic [DW-1:0]    dut_req_data_o;
    logic             dut_req_ready_i;
    logic             dut_resp_valid_i;
    logic [DW-1:0]    dut_resp_data_i;
    logic [NR-1:0]    resp_valid_o;
    logic [DW-1:0]    resp_data_o;
    logic             err_o;

    int tests = 0;
    int fails = 0;
    int exp_q[$];

    typedef struct {
        logic [NR-1:0] rv;
        logic          rdy;
        logic          rsp;
        logic [DW-1:0] rd;
        logic [NR-1:0] e_rdy;
        logic          e_dv;
        logic [DW-1:0] e_dd;
    } vec_t;

    vec_t tbl[11];

    always #5 clk_i = ~clk_i;

    rr_req_arbiter #(
        .NUM_REQ   (NR),
        .DATA_SIZE (DW),
        .MAX_OUTST (MO)
    ) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .req_valid_i      (req_valid_i),
        .req_data_i       (req_data_i),
        .req_ready_o      (req_ready_o),
        .dut_req_valid_o  (dut_req_valid_o),
        .dut_req_data_o   (dut_req_data_o),
        .dut_req_ready_i  (dut_req_ready_i),
        .dut_resp_valid_i (dut_resp_valid_i),
        .dut_resp_data_i  (dut_resp_data_i),
        .resp_valid_o     (resp_valid_o),
        .resp_data_o      (resp_data_o),
        .err_o            (err_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [NR-1:0] rv, input logic rdy, input logic rsp, input logic [DW-1:0] rd);
        @(posedge clk_i);
        #1;
        req_valid_i      = rv;
        dut_req_ready_i  = rdy;
        dut_resp_valid_i = rsp;
        dut_resp_data_i  = rd;
        #2;
    endtask

    task automatic chk_resp(input string name, input logic [DW-1:0] d);
        int id;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: no owner queued, got resp_valid_o=%b", name, resp_valid_o);
        end else begin
            id = exp_q.pop_front();
            chk({name, "_vld"}, 32'(resp_valid_o), 32'(1 << id));
            chk({name, "_dat"}, 32'(resp_data_o), 32'(d));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_rdy"},   32'(req_ready_o),     32'h0);
        chk({name, "_dvld"},  32'(dut_req_valid_o), 32'h0);
        chk({name, "_ddat"},  32'(dut_req_data_o),  32'h0);
        chk({name, "_rvld"},  32'(resp_valid_o),    32'h0);
        chk({name, "_rdat"},  32'(resp_data_o),     32'h0);
        chk({name, "_err"},   32'(err_o),           32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int caps;
        int nxt;

        req_data_i = {16'h4d4d, 16'h3c3c, 16'h2b2b, 16'h1234};

        // Fairness with requests held high and responses returned.
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0, 16'h0000};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 16'hF001, 4'b0000, 1'b1, 16'h1234};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 16'h0000};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 16'hF003, 4'b0000, 1'b1, 16'h2b2b};
        tbl[4]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0100, 1'b0, 16'h0000};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 16'hF005, 4'b0000, 1'b1, 16'h3c3c};
        tbl[6]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b1000, 1'b0, 16'h0000};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 16'hF007, 4'b0000, 1'b1, 16'h4d4d};
        tbl[8]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0, 16'h0000};
        tbl[9]  = '{4'b1111, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 16'h1234};
        tbl[10] = '{4'b0000, 1'b1, 1'b1, 16'hF00A, 4'b0000, 1'b0, 16'h0000};

        // Reset with live inputs: every output must stay low.
        rstn_i           = 1'b0;
        req_valid_i      = 4'b1111;
        dut_req_ready_i  = 1'b1;
        dut_resp_valid_i = 1'b1;
        dut_resp_data_i  = 16'hDEAD;
        repeat (2) @(posedge clk_i);
        #3;
        chk_all_zero("reset");
        req_valid_i      = '0;
        dut_resp_valid_i = 1'b0;
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rv, tbl[i].rdy, tbl[i].rsp, tbl[i].rd);
            chk($sformatf("vec%0d_rdy", i), 32'(req_ready_o), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_dvld", i), 32'(dut_req_valid_o), 32'(tbl[i].e_dv));
            if (tbl[i].e_dv) begin
                chk($sformatf("vec%0d_ddat", i), 32'(dut_req_data_o), 32'(tbl[i].e_dd));
            end
            for (int b = 0; b < NR; b++) begin
                if (tbl[i].e_rdy[b]) exp_q.push_back(b);
            end
            if (tbl[i].rsp) begin
                chk_resp($sformatf("vec%0d_resp", i), tbl[i].rd);
            end
        end
        chk("table_err", 32'(err_o), 32'h0);

        // Backpressure: five stalled cycles in HOLD, pointer must not move.
        drive(4'b1111, 1'b0, 1'b0, '0);
        chk("bp_grant", 32'(req_ready_o), 32'h2);
        exp_q.push_back(1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0, 1'b0, '0);
            chk($sformatf("bp_stall%0d_dvld", i), 32'(dut_req_valid_o), 32'h1);
            chk($sformatf("bp_stall%0d_ddat", i), 32'(dut_req_data_o), 32'h2b2b);
            chk($sformatf("bp_stall%0d_rdy", i), 32'(req_ready_o), 32'h0);
        end
        drive(4'b1111, 1'b1, 1'b0, '0);
        chk("bp_hs_dvld", 32'(dut_req_valid_o), 32'h1);
        drive(4'b1111, 1'b1, 1'b0, '0);
        chk("bp_next_grant", 32'(req_ready_o), 32'h4);
        exp_q.push_back(2);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b0000, 1'b0, 1'b1, 16'hF101);
        chk_resp("bp_resp0", 16'hF101);
        drive(4'b0000, 1'b0, 1'b1, 16'hF102);
        chk_resp("bp_resp1", 16'hF102);

        // Credit limit: exactly MO captures without responses.
        nxt  = 3;
        caps = 0;
        for (int i = 0; i < 14; i++) begin
            drive(4'b1111, 1'b1, 1'b0, '0);
            if (req_ready_o != '0) begin
                caps++;
                chk("credit_grant", 32'(req_ready_o), 32'(1 << nxt));
                exp_q.push_back(nxt);
                nxt = (nxt + 1) % NR;
            end
        end
        chk("credit_caps", 32'(caps), 32'(MO));
        drive(4'b1111, 1'b1, 1'b1, 16'hF201);
        chk("credit_full_rdy", 32'(req_ready_o), 32'h0);
        chk_resp("credit_resp", 16'hF201);
        caps = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'b1111, 1'b1, 1'b0, '0);
            if (req_ready_o != '0) begin
                caps++;
                chk("credit_regrant", 32'(req_ready_o), 32'(1 << nxt));
                exp_q.push_back(nxt);
                nxt = (nxt + 1) % NR;
            end
        end
        chk("credit_extra_caps", 32'(caps), 32'h1);
        for (int i = 0; i < MO; i++) begin
            drive(4'b0000, 1'b1, 1'b1, 16'(16'hF210 + i));
            chk_resp($sformatf("credit_drain%0d", i), 16'(16'hF210 + i));
        end

        // Routing: grants 2, 0, 3 then responses A, B, C.
        drive(4'b0100, 1'b1, 1'b0, '0);
        chk("route_g2", 32'(req_ready_o), 32'h4);
        exp_q.push_back(2);
        drive(4'b0000, 1'b1, 1'b0, '0);
        chk("route_g2_ddat", 32'(dut_req_data_o), 32'h3c3c);
        drive(4'b0001, 1'b1, 1'b0, '0);
        chk("route_g0", 32'(req_ready_o), 32'h1);
        exp_q.push_back(0);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b1000, 1'b1, 1'b0, '0);
        chk("route_g3", 32'(req_ready_o), 32'h8);
        exp_q.push_back(3);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b0000, 1'b0, 1'b1, 16'hAAAA);
        chk_resp("route_A", 16'hAAAA);
        drive(4'b0000, 1'b0, 1'b1, 16'hBBBB);
        chk_resp("route_B", 16'hBBBB);
        drive(4'b0000, 1'b0, 1'b1, 16'hCCCC);
        chk_resp("route_C", 16'hCCCC);

        // Capture and response in the same cycle leave one request in flight.
        drive(4'b0001, 1'b1, 1'b0, '0);
        exp_q.push_back(0);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b0010, 1'b1, 1'b1, 16'h5151);
        chk("same_cyc_rdy", 32'(req_ready_o), 32'h2);
        exp_q.push_back(1);
        chk_resp("same_cyc_resp", 16'h5151);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b0000, 1'b0, 1'b1, 16'h5252);
        chk_resp("same_cyc_last", 16'h5252);

        // Orphan response: flagged, not routed, sticky.
        chk("pre_err", 32'(err_o), 32'h0);
        drive(4'b0000, 1'b0, 1'b1, 16'hEEEE);
        chk("orphan_rvld", 32'(resp_valid_o), 32'h0);
        drive(4'b0000, 1'b0, 1'b0, '0);
        chk("orphan_err", 32'(err_o), 32'h1);
        repeat (3) drive(4'b0000, 1'b0, 1'b0, '0);
        chk("err_sticky", 32'(err_o), 32'h1);

        // Reset in HOLD with two tags outstanding.
        drive(4'b0001, 1'b1, 1'b0, '0);
        drive(4'b0000, 1'b1, 1'b0, '0);
        drive(4'b0010, 1'b0, 1'b0, '0);
        drive(4'b0010, 1'b0, 1'b0, '0);
        chk("rst_hold_dvld", 32'(dut_req_valid_o), 32'h1);
        dut_resp_valid_i = 1'b1;
        dut_resp_data_i  = 16'h6666;
        rstn_i           = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_q.delete();
        dut_resp_valid_i = 1'b0;
        req_valid_i      = '0;
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        drive(4'b0000, 1'b0, 1'b1, 16'h7777);
        chk("postrst_rvld", 32'(resp_valid_o), 32'h0);
        chk("postrst_dvld", 32'(dut_req_valid_o), 32'h0);
        drive(4'b1111, 1'b1, 1'b0, '0);
        chk("postrst_err", 32'(err_o), 32'h1);
        chk("postrst_grant", 32'(req_ready_o), 32'h1);
        exp_q.push_back(0);
        drive(4'b0000, 1'b1, 1'b0, '0);
        chk("postrst_ddat", 32'(dut_req_data_o), 32'h1234);
        drive(4'b0000, 1'b0, 1'b1, 16'h8888);
        chk_resp("postrst_resp", 16'h8888);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
